conv_host: RTL and testbench
============================

# conv_host

Host-side counterpart of the binary-convolution DUT. Owns the input/output SRAM and the weight memory the DUT addresses, and answers its read and write ports. Drives the `dut_run`/`dut_busy` start handshake and times each run. Provides a backdoor port so a bench or system controller can preload memories and read back results.

## Interface
- `ADDR_W`, 12: address width of both memories (2^ADDR_W words each).
- `DATA_W`, 16: word width.
- `TIMEOUT_CYCLES`, 16'hFFFF: max cycles in BUSY before abort.
- `BUSY_WAIT`, 4: max cycles after the `dut_run` pulse for `dut_busy` to rise.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state and outputs clear immediately.
- `host_start`  in  1  begin a run; sampled in IDLE only.
- `host_done`  out  1  one-cycle pulse at the end of a successful run.
- `host_timeout`  out  1  sticky abort flag; cleared by `host_start` or `reset`.
- `cycle_count`  out  16  BUSY cycles of the last run; saturates at 16'hFFFF.
- `wr_count`  out  ADDR_W+1  DUT writes in the last run (see Configuration).
- `host_wr_en`  in  1  backdoor write.
- `host_sel`  in  1  backdoor target: 0 = SRAM, 1 = weight memory.
- `host_addr`  in  ADDR_W  backdoor address.
- `host_wr_data`  in  DATA_W  backdoor write data.
- `host_rd_data`  out  DATA_W  backdoor read data, 1-cycle latency.
- `dut_run`  out  1  start pulse to the DUT.
- `dut_busy`  in  1  DUT busy.
- `dut_sram_read_address`  in  ADDR_W  DUT SRAM read address.
- `sram_dut_read_data`  out  DATA_W  SRAM read data.
- `dut_sram_write_enable`  in  1  DUT SRAM write strobe.
- `dut_sram_write_address`  in  ADDR_W  DUT SRAM write address.
- `dut_sram_write_data`  in  DATA_W  DUT SRAM write data.
- `dut_wmem_read_address`  in  ADDR_W  DUT weight-memory read address.
- `wmem_dut_read_data`  out  DATA_W  weight-memory read data.

## Operation
- FSM states: IDLE, RUN, WAIT_BUSY, BUSY, DONE, TIMEOUT.
  - IDLE: if `host_start`, clear `host_timeout`, `cycle_count`, `wr_count`, then go to RUN.
  - RUN: `dut_run`=1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: if `dut_busy`, go to BUSY. If `dut_busy` has not risen after BUSY_WAIT cycles in this state, go to TIMEOUT.
  - BUSY: increment `cycle_count` each cycle, saturating.
    - If `dut_busy`=0, go to DONE.
    - Else, if `cycle_count` == TIMEOUT_CYCLES-1, go to TIMEOUT.
  - DONE: `host_done`=1 for one cycle; go to IDLE.
  - TIMEOUT: set `host_timeout`; go to IDLE.
- DUT ports:
  - DUT writes commit only in WAIT_BUSY and BUSY; they are ignored in every other state.
  - DUT reads are serviced in every state.
- Backdoor:
  - Writes commit in IDLE only; they are ignored in every other state.
  - Reads are always serviced.
- SRAM read-during-write to the same address returns the old data (read-first).
- Addresses are naturally ADDR_W wide; there is no wrap logic or range check.
- Memories are not cleared by `reset`; their contents are undefined until written.
- `host_start` outside IDLE is ignored.

## Timing
- Reset values: every output is 0.
- Read latency: the address presented at edge N produces data after edge N+1. This applies to the SRAM, the weight memory and `host_rd_data`.
- A write presented at edge N is readable by a read address presented at edge N+1.
- Start latency: `host_start` at edge N gives `dut_run` high in cycle N+1; earliest BUSY entry is cycle N+2.
- `host_done` is asserted in the cycle after the first sampled `dut_busy`=0.
- `reset` asserted mid-run forces IDLE with `dut_run` low. Memory contents are retained.

## Configuration
- `CONV_HOST_WRCOUNT_EN`:
  - Defined: `wr_count` increments on each committed DUT SRAM write and saturates at all-ones.
  - Undefined: no counter logic is built and `wr_count` is tied to 0.

## Structure
- Package `conv_pkg` holds:
  - the ADDR_W and DATA_W defaults;
  - the `host_state_t` enum of the six states;
  - the `HOST_SEL_SRAM` / `HOST_SEL_WMEM` constants.
- Sub-module `conv_sram`: one synchronous 1R1W read-first memory with registered read. It is instantiated twice:
  - SRAM copy: its write port is muxed between DUT and backdoor.
  - Weight-memory copy: backdoor write only.
- `host_rd_data` is muxed by a registered `host_sel`.
- The SRAM needs a second read path for the backdoor. Implement it either as a third `conv_sram` instance that mirrors all SRAM writes, or as a read-port mux that is valid in IDLE only. Choose one and document it in the RTL header.

## Test plan
- Backdoor write 16'hA5A5 to SRAM addr 12'h010 in IDLE, then DUT reads 12'h010 → `sram_dut_read_data`=16'hA5A5 one cycle later.
- Start a run with `dut_busy` driven high for 10 cycles → one `dut_run` pulse, `cycle_count`=10, `host_done` pulse, `host_timeout`=0.
- Start a run with `dut_busy` held 0 → `host_timeout`=1 after BUSY_WAIT cycles, no `host_done`.
- TIMEOUT_CYCLES=20 with `dut_busy` stuck high → TIMEOUT at `cycle_count`=20, then IDLE.
- In BUSY, DUT writes 3 words (addrs 12'h100..12'h102), then read back via backdoor → data matches; `wr_count`=3 with the macro defined, 0 without.
- Assert `reset` mid-BUSY → outputs 0 immediately, state IDLE, prior SRAM data still readable.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults, FSM state type and backdoor target encoding for conv_host.
package conv_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT_BUSY,
        BUSY,
        DONE,
        TIMEOUT
    } host_state_t;

    localparam logic HOST_SEL_SRAM = 1'b0;
    localparam logic HOST_SEL_WMEM = 1'b1;
endpackage

// File: rtl/conv_sram.sv
// Synchronous 1R1W memory with registered read; contents are never reset.
module conv_sram
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Sampling the array on the same edge as the write yields read-first data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/conv_host.sv
// Host side of the binary-convolution DUT: memories, run handshake, run timing.
// Backdoor reads use mirror copies of each memory that see every write, so they
// are valid in every state. Optional macro CONV_HOST_WRCOUNT_EN builds wr_count.
module conv_host
    import conv_pkg::*;
#(
    parameter int          ADDR_W         = ADDR_W_DEF,
    parameter int          DATA_W         = DATA_W_DEF,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
    parameter int          BUSY_WAIT      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_start,
    output logic              host_done,
    output logic              host_timeout,
    output logic [15:0]       cycle_count,
    output logic [ADDR_W:0]   wr_count,
    input  logic              host_wr_en,
    input  logic              host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              dut_run,
    input  logic              dut_busy,
    input  logic [ADDR_W-1:0] dut_sram_read_address,
    output logic [DATA_W-1:0] sram_dut_read_data,
    input  logic              dut_sram_write_enable,
    input  logic [ADDR_W-1:0] dut_sram_write_address,
    input  logic [DATA_W-1:0] dut_sram_write_data,
    input  logic [ADDR_W-1:0] dut_wmem_read_address,
    output logic [DATA_W-1:0] wmem_dut_read_data
);
    host_state_t       state, state_next;
    logic [15:0]       wait_cnt;
    logic              sel_q;
    logic              dut_wr, bd_wr, sram_we, wmem_we;
    logic              wait_expired, busy_expired, start_run;
    logic [ADDR_W-1:0] sram_waddr;
    logic [DATA_W-1:0] sram_wdata, sram_bd_data, wmem_bd_data;

    assign start_run    = (state == IDLE) && host_start;
    assign dut_wr       = dut_sram_write_enable && (state == WAIT_BUSY || state == BUSY);
    assign bd_wr        = host_wr_en && (state == IDLE);
    assign sram_we      = dut_wr || (bd_wr && host_sel == HOST_SEL_SRAM);
    assign wmem_we      = bd_wr && host_sel == HOST_SEL_WMEM;
    assign sram_waddr   = dut_wr ? dut_sram_write_address : host_addr;
    assign sram_wdata   = dut_wr ? dut_sram_write_data : host_wr_data;
    assign wait_expired = (wait_cnt == 16'(BUSY_WAIT - 1));
    assign busy_expired = (cycle_count == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (host_start) state_next = RUN;
            RUN:       state_next = WAIT_BUSY;
            WAIT_BUSY: if (dut_busy) state_next = BUSY;
                       else if (wait_expired) state_next = TIMEOUT;
            BUSY:      if (!dut_busy) state_next = DONE;
                       else if (busy_expired) state_next = TIMEOUT;
            DONE:      state_next = IDLE;
            TIMEOUT:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        dut_run   = (state == RUN);
        host_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count  <= '0;
            host_timeout <= 1'b0;
            wait_cnt     <= '0;
            sel_q        <= HOST_SEL_SRAM;
        end else begin
            sel_q    <= host_sel;
            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 16'd1 : 16'd0;
            if (start_run) begin
                cycle_count  <= '0;
                host_timeout <= 1'b0;
            end else begin
                if (state == BUSY && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
                if (state == TIMEOUT) host_timeout <= 1'b1;
            end
        end
    end

`ifdef CONV_HOST_WRCOUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
        end else if (start_run) begin
            wr_count <= '0;
        end else if (dut_wr && wr_count != '1) begin
            wr_count <= wr_count + {{ADDR_W{1'b0}}, 1'b1};
        end
    end
`else
    assign wr_count = '0;
`endif

    // DUT-facing copies and their backdoor-read mirrors share identical write ports.
    conv_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram_dut (
        .clk(clk), .reset(reset), .we(sram_we), .waddr(sram_waddr), .wdata(sram_wdata),
        .raddr(dut_sram_read_address), .rdata(sram_dut_read_data)
    );
    conv_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram_bd (
        .clk(clk), .reset(reset), .we(sram_we), .waddr(sram_waddr), .wdata(sram_wdata),
        .raddr(host_addr), .rdata(sram_bd_data)
    );
    conv_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wmem_dut (
        .clk(clk), .reset(reset), .we(wmem_we), .waddr(host_addr), .wdata(host_wr_data),
        .raddr(dut_wmem_read_address), .rdata(wmem_dut_read_data)
    );
    conv_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wmem_bd (
        .clk(clk), .reset(reset), .we(wmem_we), .waddr(host_addr), .wdata(host_wr_data),
        .raddr(host_addr), .rdata(wmem_bd_data)
    );

    assign host_rd_data = (sel_q == HOST_SEL_WMEM) ? wmem_bd_data : sram_bd_data;
endmodule

// File: tb/tb_conv_host.sv
// Self-checking bench for conv_host: vector table, randomized runs vs. a memory/run model.
module tb_conv_host;
    localparam int BUSY_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_start, host_done, host_timeout;
    logic [15:0] cycle_count;
    logic [12:0] wr_count;
    logic        host_wr_en, host_sel;
    logic [11:0] host_addr;
    logic [15:0] host_wr_data, host_rd_data;
    logic        dut_run, dut_busy;
    logic [11:0] draddr, dwaddr, wraddr;
    logic [15:0] sram_dut_read_data, dwdata, wmem_dut_read_data;
    logic        dwe;

    // Second instance with a short BUSY timeout; unused inputs held at 0.
    logic        t_start, t_busy, t_done, t_timeout, t_run;
    logic [15:0] t_cycle_count, t_rd, t_srd, t_wrd;
    logic [12:0] t_wr_count;
    logic        t_zero1 = 1'b0;
    logic [11:0] t_zero_a = '0;
    logic [15:0] t_zero_d = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] sram_m [int];
    logic [15:0] wmem_m [int];

    typedef struct packed {
        logic        sel;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    conv_host u_dut (
        .clk(clk), .reset(reset), .host_start(host_start), .host_done(host_done),
        .host_timeout(host_timeout), .cycle_count(cycle_count), .wr_count(wr_count),
        .host_wr_en(host_wr_en), .host_sel(host_sel), .host_addr(host_addr),
        .host_wr_data(host_wr_data), .host_rd_data(host_rd_data), .dut_run(dut_run),
        .dut_busy(dut_busy), .dut_sram_read_address(draddr),
        .sram_dut_read_data(sram_dut_read_data), .dut_sram_write_enable(dwe),
        .dut_sram_write_address(dwaddr), .dut_sram_write_data(dwdata),
        .dut_wmem_read_address(wraddr), .wmem_dut_read_data(wmem_dut_read_data)
    );

    conv_host #(.TIMEOUT_CYCLES(16'd20)) u_short (
        .clk(clk), .reset(reset), .host_start(t_start), .host_done(t_done),
        .host_timeout(t_timeout), .cycle_count(t_cycle_count), .wr_count(t_wr_count),
        .host_wr_en(t_zero1), .host_sel(t_zero1), .host_addr(t_zero_a),
        .host_wr_data(t_zero_d), .host_rd_data(t_rd), .dut_run(t_run),
        .dut_busy(t_busy), .dut_sram_read_address(t_zero_a),
        .sram_dut_read_data(t_srd), .dut_sram_write_enable(t_zero1),
        .dut_sram_write_address(t_zero_a), .dut_sram_write_data(t_zero_d),
        .dut_wmem_read_address(t_zero_a), .wmem_dut_read_data(t_wrd)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic bd_write(input logic sel, input logic [11:0] a, input logic [15:0] d);
        host_wr_en = 1'b1; host_sel = sel; host_addr = a; host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
        if (sel) wmem_m[int'(a)] = d;
        else sram_m[int'(a)] = d;
    endtask

    task automatic bd_read_chk(input string nm, input logic sel, input logic [11:0] a,
                               input logic [15:0] exp);
        host_sel = sel; host_addr = a;
        @(negedge clk);
        chk(nm, host_rd_data, exp);
    endtask

    // A run where the DUT holds busy for L sampled cycles; expect L BUSY cycles.
    task automatic run_busy(input int L);
        int          nwr = 0;
        logic [11:0] ra, wa;
        logic [15:0] exp_rd, exp_w;
        bit          have_exp = 0;
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        chk("run_pulse", dut_run, 1);
        chk("run_clr_timeout", host_timeout, 0);
        chk("run_clr_count", cycle_count, 0);
        // Writes presented in RUN and any backdoor write during the run are dropped.
        dwe = 1'b1; dwaddr = 12'h100; dwdata = 16'hDEAD; dut_busy = 1'b1;
        host_wr_en = 1'b1; host_sel = 1'b0; host_addr = 12'h101; host_wr_data = 16'hBEEF;
        for (int i = 1; i <= L + 1; i++) begin
            @(negedge clk);
            if (i == 1) chk("run_single_pulse", dut_run, 0);
            if (i == 2) host_start = 1'b1;
            chk("run_no_early_done", host_done, 0);
            if (have_exp) begin
                chk("run_dut_rd", sram_dut_read_data, exp_rd);
                chk("run_wmem_rd", wmem_dut_read_data, exp_w);
            end
            ra = 12'h100 + 12'($urandom_range(0, 15));
            wa = 12'($urandom_range(0, 31));
            draddr = ra; exp_rd = sram_m[int'(ra)];
            wraddr = wa; exp_w = wmem_m[int'(wa)];
            have_exp = 1;
            dwe = 1'($urandom_range(0, 1));
            dwaddr = ($urandom_range(0, 3) == 0) ? ra : 12'h100 + 12'($urandom_range(0, 15));
            dwdata = 16'($urandom);
            if (dwe) begin
                sram_m[int'(dwaddr)] = dwdata;
                nwr++;
            end
            if (i == L + 1) dut_busy = 1'b0;
        end
        @(negedge clk);
        dwe = 1'b0; host_wr_en = 1'b0; host_start = 1'b0;
        chk("run_dut_rd_last", sram_dut_read_data, exp_rd);
        chk("run_done", host_done, 1);
        chk("run_cycle_count", cycle_count, L);
        chk("run_no_timeout", host_timeout, 0);
`ifdef CONV_HOST_WRCOUNT_EN
        chk("run_wr_count", wr_count, nwr);
`else
        chk("run_wr_count", wr_count, 0);
`endif
        @(negedge clk);
        chk("run_done_one_cycle", host_done, 0);
        for (int a = 'h100; a < 'h110; a++) bd_read_chk("run_readback", 1'b0, 12'(a), sram_m[a]);
    endtask

    initial begin
        int  n;
        bit  seen_done;
        reset = 1'b1; host_start = 0; host_wr_en = 0; host_sel = 0; host_addr = '0;
        host_wr_data = '0; dut_busy = 0; draddr = '0; dwaddr = '0; wraddr = '0;
        dwdata = '0; dwe = 0; t_start = 0; t_busy = 0;
        repeat (2) @(negedge clk);
        chk("rst_done", host_done, 0);
        chk("rst_timeout", host_timeout, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_run", dut_run, 0);
        chk("rst_host_rd", host_rd_data, 0);
        chk("rst_sram_rd", sram_dut_read_data, 0);
        chk("rst_wmem_rd", wmem_dut_read_data, 0);
        reset = 1'b0;
        @(negedge clk);

        tbl[0] = '{1'b0, 12'h010, 16'hA5A5, 16'hA5A5};
        tbl[1] = '{1'b1, 12'h010, 16'h5A5A, 16'h5A5A};
        tbl[2] = '{1'b0, 12'h000, 16'h0001, 16'h0001};
        tbl[3] = '{1'b0, 12'hFFF, 16'hFFFF, 16'hFFFF};
        tbl[4] = '{1'b1, 12'hFFF, 16'h8000, 16'h8000};
        tbl[5] = '{1'b0, 12'h020, 16'h1111, 16'h2222};
        tbl[6] = '{1'b0, 12'h020, 16'h2222, 16'h2222};
        tbl[7] = '{1'b1, 12'h000, 16'h0F0F, 16'h0F0F};
        foreach (tbl[i]) bd_write(tbl[i].sel, tbl[i].addr, tbl[i].wdata);
        foreach (tbl[i]) bd_read_chk("tbl_read", tbl[i].sel, tbl[i].addr, tbl[i].exp);

        draddr = 12'h010; wraddr = 12'h010;
        @(negedge clk);
        chk("dut_sram_rd_a5a5", sram_dut_read_data, 16'hA5A5);
        chk("dut_wmem_rd_5a5a", wmem_dut_read_data, 16'h5A5A);

        for (int a = 0; a < 16; a++) bd_write(1'b0, 12'h100 + 12'(a), 16'($urandom));
        for (int a = 0; a < 32; a++) bd_write(1'b1, 12'(a), 16'($urandom));
        for (int k = 0; k < 40; k++) begin
            logic        s = 1'($urandom_range(0, 1));
            logic [11:0] a = s ? 12'($urandom_range(0, 31)) : 12'h100 + 12'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) bd_write(s, a, 16'($urandom));
            else bd_read_chk("rand_bd_read", s, a, s ? wmem_m[int'(a)] : sram_m[int'(a)]);
        end

        run_busy(10);

        // Busy never rises: abort after BUSY_WAIT cycles in WAIT_BUSY.
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        chk("to_run", dut_run, 1);
        n = 0; seen_done = 0;
        while (host_timeout !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            if (host_done === 1'b1) seen_done = 1;
        end
        chk("to_latency", n, BUSY_WAIT + 2);
        chk("to_no_done", seen_done, 0);
        chk("to_count", cycle_count, 0);

        for (int r = 0; r < 6; r++) run_busy($urandom_range(1, 30));

        // Short-timeout instance with busy stuck high.
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0; t_busy = 1'b1;
        chk("short_run", t_run, 1);
        n = 0; seen_done = 0;
        while (t_timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (t_done === 1'b1) seen_done = 1;
        end
        chk("short_latency", n, 23);
        chk("short_count", t_cycle_count, 20);
        chk("short_no_done", seen_done, 0);
        t_busy = 1'b0; t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        chk("short_restart_run", t_run, 1);
        chk("short_timeout_cleared", t_timeout, 0);
        chk("short_count_cleared", t_cycle_count, 0);

        // Asynchronous reset in the middle of BUSY.
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0; dut_busy = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_busy_counting", cycle_count, 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", cycle_count, 0);
        chk("arst_run", dut_run, 0);
        chk("arst_done", host_done, 0);
        chk("arst_timeout", host_timeout, 0);
        chk("arst_wr_count", wr_count, 0);
        chk("arst_host_rd", host_rd_data, 0);
        chk("arst_sram_rd", sram_dut_read_data, 0);
        @(negedge clk);
        reset = 1'b0; dut_busy = 1'b0;
        @(negedge clk);
        chk("arst_idle_run", dut_run, 0);
        bd_read_chk("arst_keep_a5a5", 1'b0, 12'h010, 16'hA5A5);
        bd_read_chk("arst_keep_105", 1'b0, 12'h105, sram_m['h105]);
        bd_write(1'b0, 12'h030, 16'h3C3C);
        bd_read_chk("arst_idle_bd_write", 1'b0, 12'h030, 16'h3C3C);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
